// File: rtl/reu_exec_ctrl.sv
`timescale 1ns/1ps
// REU register file ($DF00-$DF0A), transfer arm/launch FSM and the CA/REUA/length
// counters stepped by the DMA sequencer. All state updates on the falling edge of PHI2.
//
//   state | meaning
//   IDLE  | no transfer pending; CPU owns the registers
//   ARMED | execute set with FF00 trigger enabled; waiting for a $FF00 write
//   RUN   | Execute asserted; sequencer steps the counters
//   DONE  | one-cycle wrap-up: clear execute, set FF00-disable, optional autoload
module reu_exec_ctrl #(
  parameter int REUA_BITS = 19
) (
  input  logic                 PHI2,
  input  logic                 nRESET,
  input  logic                 RegReset,
  input  logic                 RegWR,
  input  logic                 RegRD,
  input  logic [3:0]           RegA,
  input  logic [7:0]           Din,
  output logic [7:0]           Dout,
  input  logic                 FF00WR,
  input  logic                 IncCA,
  input  logic                 DecLen,
  input  logic                 IncREUA,
  input  logic                 XferEnd,
  input  logic                 SetEndOfBlock,
  input  logic                 SetVerifyErr,
  output logic                 Execute,
  output logic [1:0]           XferType,
  output logic                 Length1,
  output logic [15:0]          CA,
  output logic [REUA_BITS-1:0] REUA,
  output logic                 nIRQ
);

  localparam int BW = REUA_BITS - 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0]           CMD_RST  = 8'h10;
  localparam logic [15:0]          LEN_RST  = 16'hFFFF;
  localparam logic [REUA_BITS-1:0] REUA_ZERO = '0;
  localparam logic [REUA_BITS-1:0] REUA_ONE  = REUA_BITS'(1);
  localparam logic                 STAT_B4  = (REUA_BITS >= 19);

  logic [1:0]           state_q, state_d;
  logic                 exec_q, exec_d;
  logic                 eob_q, eob_d;
  logic                 verr_q, verr_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [15:0]          ca_q, ca_d, ca_sh_q, ca_sh_d;
  logic [REUA_BITS-1:0] reua_q, reua_d, reua_sh_q, reua_sh_d;
  logic [15:0]          len_q, len_d, len_sh_q, len_sh_d;
  logic [2:0]           mask_q, mask_d;
  logic [1:0]           actl_q, actl_d;

  logic                 wr_ok;
  logic                 cmd_wr;
  logic                 irq;
  logic [7:0]           bank_rd;

  assign wr_ok  = RegWR && ((state_q == S_IDLE) || (state_q == S_ARMED));
  assign cmd_wr = wr_ok && (RegA == 4'd1);
  assign irq    = mask_q[2] && ((eob_q && mask_q[1]) || (verr_q && mask_q[0]));

  always_comb begin
    state_d   = state_q;
    eob_d     = eob_q;
    verr_d    = verr_q;
    cmd_d     = cmd_q;
    ca_d      = ca_q;
    ca_sh_d   = ca_sh_q;
    reua_d    = reua_q;
    reua_sh_d = reua_sh_q;
    len_d     = len_q;
    len_sh_d  = len_sh_q;
    mask_d    = mask_q;
    actl_d    = actl_q;

    if (IncCA && !actl_q[1])   ca_d   = ca_q + 16'd1;
    if (IncREUA && !actl_q[0]) reua_d = reua_q + REUA_ONE;
    if (DecLen)                len_d  = len_q - 16'd1;

    if (wr_ok) begin
      case (RegA)
        4'd1:  cmd_d = Din;
        4'd2:  begin ca_d[7:0]    = Din; ca_sh_d[7:0]    = Din; end
        4'd3:  begin ca_d[15:8]   = Din; ca_sh_d[15:8]   = Din; end
        4'd4:  begin reua_d[7:0]  = Din; reua_sh_d[7:0]  = Din; end
        4'd5:  begin reua_d[15:8] = Din; reua_sh_d[15:8] = Din; end
        4'd6:  begin
          reua_d[REUA_BITS-1:16]    = Din[BW-1:0];
          reua_sh_d[REUA_BITS-1:16] = Din[BW-1:0];
        end
        4'd7:  begin len_d[7:0]   = Din; len_sh_d[7:0]   = Din; end
        4'd8:  begin len_d[15:8]  = Din; len_sh_d[15:8]  = Din; end
        4'd9:  mask_d = Din[7:5];
        4'd10: actl_d = Din[7:6];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_wr && Din[7]) state_d = Din[4] ? S_RUN : S_ARMED;
      end
      S_ARMED: begin
        if (FF00WR)      state_d = S_RUN;
        else if (cmd_wr) state_d = !Din[7] ? S_IDLE : (Din[4] ? S_RUN : S_ARMED);
      end
      S_RUN: begin
        if (XferEnd) state_d = S_DONE;
      end
      default: begin
        cmd_d[7] = 1'b0;
        cmd_d[4] = 1'b1;
        if (cmd_q[5]) begin
          ca_d   = ca_sh_q;
          reua_d = reua_sh_q;
          len_d  = len_sh_q;
        end
        state_d = S_IDLE;
      end
    endcase

    // set events take priority over the read-to-clear
    if (RegRD && (RegA == 4'd0)) begin
      eob_d  = 1'b0;
      verr_d = 1'b0;
    end
    if (SetEndOfBlock) eob_d  = 1'b1;
    if (SetVerifyErr)  verr_d = 1'b1;

    if (RegReset) begin
      state_d   = S_IDLE;
      eob_d     = 1'b0;
      verr_d    = 1'b0;
      cmd_d     = CMD_RST;
      ca_d      = 16'h0000;
      ca_sh_d   = 16'h0000;
      reua_d    = REUA_ZERO;
      reua_sh_d = REUA_ZERO;
      len_d     = LEN_RST;
      len_sh_d  = LEN_RST;
      mask_d    = 3'b000;
      actl_d    = 2'b00;
    end

    exec_d = (state_d == S_RUN);
  end

  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= S_IDLE;
      exec_q    <= 1'b0;
      eob_q     <= 1'b0;
      verr_q    <= 1'b0;
      cmd_q     <= CMD_RST;
      ca_q      <= 16'h0000;
      ca_sh_q   <= 16'h0000;
      reua_q    <= REUA_ZERO;
      reua_sh_q <= REUA_ZERO;
      len_q     <= LEN_RST;
      len_sh_q  <= LEN_RST;
      mask_q    <= 3'b000;
      actl_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      exec_q    <= exec_d;
      eob_q     <= eob_d;
      verr_q    <= verr_d;
      cmd_q     <= cmd_d;
      ca_q      <= ca_d;
      ca_sh_q   <= ca_sh_d;
      reua_q    <= reua_d;
      reua_sh_q <= reua_sh_d;
      len_q     <= len_d;
      len_sh_q  <= len_sh_d;
      mask_q    <= mask_d;
      actl_q    <= actl_d;
    end
  end

  always_comb begin
    bank_rd         = 8'hFF;
    bank_rd[BW-1:0] = reua_q[REUA_BITS-1:16];
  end

  always_comb begin
    case (RegA)
      4'd0:    Dout = {irq, eob_q, verr_q, STAT_B4, 4'b0000};
      4'd1:    Dout = cmd_q;
      4'd2:    Dout = ca_q[7:0];
      4'd3:    Dout = ca_q[15:8];
      4'd4:    Dout = reua_q[7:0];
      4'd5:    Dout = reua_q[15:8];
      4'd6:    Dout = bank_rd;
      4'd7:    Dout = len_q[7:0];
      4'd8:    Dout = len_q[15:8];
      4'd9:    Dout = {mask_q, 5'h1F};
      4'd10:   Dout = {actl_q, 6'h3F};
      default: Dout = 8'hFF;
    endcase
  end

  assign Execute  = exec_q;
  assign XferType = cmd_q[1:0];
  assign Length1  = (len_q == 16'd1);
  assign CA       = ca_q;
  assign REUA     = reua_q;
  assign nIRQ     = !irq;

endmodule

// File: tb/tb_reu_exec_ctrl.sv
`timescale 1ns/1ps
// Directed bench for reu_exec_ctrl: stimulus pushes hand-computed expectations into a
// queue; a monitor pops and compares them on the next PHI2 rising edge (or on demand).
module tb_reu_exec_ctrl;

  localparam int RB = 19;

  logic          PHI2 = 1'b0;
  logic          clk_en = 1'b1;
  logic          nRESET = 1'b0;
  logic          RegReset = 1'b0, RegWR = 1'b0, RegRD = 1'b0;
  logic [3:0]    RegA = 4'd0;
  logic [7:0]    Din = 8'd0;
  logic [7:0]    Dout;
  logic          FF00WR = 1'b0, IncCA = 1'b0, DecLen = 1'b0, IncREUA = 1'b0;
  logic          XferEnd = 1'b0, SetEndOfBlock = 1'b0, SetVerifyErr = 1'b0;
  logic          Execute, Length1, nIRQ;
  logic [1:0]    XferType;
  logic [15:0]   CA;
  logic [RB-1:0] REUA;

  reu_exec_ctrl #(.REUA_BITS(RB)) dut (
    .PHI2(PHI2), .nRESET(nRESET), .RegReset(RegReset), .RegWR(RegWR), .RegRD(RegRD),
    .RegA(RegA), .Din(Din), .Dout(Dout), .FF00WR(FF00WR), .IncCA(IncCA), .DecLen(DecLen),
    .IncREUA(IncREUA), .XferEnd(XferEnd), .SetEndOfBlock(SetEndOfBlock),
    .SetVerifyErr(SetVerifyErr), .Execute(Execute), .XferType(XferType), .Length1(Length1),
    .CA(CA), .REUA(REUA), .nIRQ(nIRQ)
  );

  initial forever #5 if (clk_en) PHI2 = ~PHI2;

  localparam int K_DOUT = 0, K_EXEC = 1, K_LEN1 = 2, K_CA = 3, K_REUA = 4, K_NIRQ = 5;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_ev;

  function automatic logic [31:0] observe(input int k);
    case (k)
      K_DOUT:  return {24'd0, Dout};
      K_EXEC:  return {31'd0, Execute};
      K_LEN1:  return {31'd0, Length1};
      K_CA:    return {16'd0, CA};
      K_REUA:  return 32'(REUA);
      default: return {31'd0, nIRQ};
    endcase
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(posedge PHI2 or chk_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = observe(e.kind);
        n_cmp++;
        if (got !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d expectations pending", sb_q.size());
    $fatal(1, "timeout");
  end

  task automatic expect_v(input string nm, input int k, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.kind = k;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge PHI2);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    RegWR = 1'b1; RegA = a; Din = d;
    tick();
    RegWR = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [7:0] v,
                        input logic rd = 1'b0);
    RegA = a; RegRD = rd;
    expect_v(nm, K_DOUT, {24'd0, v});
    tick();
    RegRD = 1'b0;
  endtask

  task automatic strobe(input logic ca, input logic ra, input logic dl);
    IncCA = ca; IncREUA = ra; DecLen = dl;
    tick();
    IncCA = 1'b0; IncREUA = 1'b0; DecLen = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    nRESET = 1'b1;
    tick();

    // reset state
    expect_v("rst_exec", K_EXEC, 32'd0);
    expect_v("rst_nirq", K_NIRQ, 32'd1);
    expect_v("rst_len1", K_LEN1, 32'd0);
    expect_v("rst_ca",   K_CA,   32'h0);
    rd_chk("rst_status", 4'd0, 8'h10);
    rd_chk("rst_cmd",    4'd1, 8'h10);
    rd_chk("rst_bank",   4'd6, 8'hF8);
    rd_chk("rst_len_lo", 4'd7, 8'hFF);
    rd_chk("rst_len_hi", 4'd8, 8'hFF);
    rd_chk("rst_mask",   4'd9, 8'h1F);
    rd_chk("rst_actl",   4'd10, 8'h3F);
    rd_chk("rst_unused", 4'd12, 8'hFF);

    // immediate launch
    wr(4'd2, 8'h00); wr(4'd3, 8'h10);
    wr(4'd4, 8'h00); wr(4'd5, 8'h02); wr(4'd6, 8'h00);
    wr(4'd7, 8'h03); wr(4'd8, 8'h00);
    expect_v("imm_ca_load", K_CA, 32'h1000);
    expect_v("imm_reua_load", K_REUA, 32'h00200);
    wr(4'd1, 8'h90);
    expect_v("imm_exec_rise", K_EXEC, 32'd1);
    strobe(1, 1, 1);
    expect_v("imm_len1_at2", K_LEN1, 32'd0);
    strobe(1, 1, 1);
    expect_v("imm_len1_at1", K_LEN1, 32'd1);
    strobe(1, 1, 1);
    expect_v("imm_ca_end",   K_CA,   32'h1003);
    expect_v("imm_reua_end", K_REUA, 32'h00203);
    expect_v("imm_len1_at0", K_LEN1, 32'd0);
    XferEnd = 1'b1; tick(); XferEnd = 1'b0;
    expect_v("imm_exec_fall", K_EXEC, 32'd0);
    tick();
    rd_chk("imm_cmd_after", 4'd1, 8'h10);
    rd_chk("imm_len_keep",  4'd7, 8'h00);
    expect_v("imm_ca_keep", K_CA, 32'h1003);

    // FF00 trigger, and FF00 ignored when idle
    FF00WR = 1'b1; tick(); FF00WR = 1'b0;
    expect_v("ff00_idle_ignored", K_EXEC, 32'd0);
    wr(4'd1, 8'h80);
    for (int i = 0; i < 10; i++) begin
      expect_v("ff00_armed_wait", K_EXEC, 32'd0);
      tick();
    end
    FF00WR = 1'b1; tick(); FF00WR = 1'b0;
    expect_v("ff00_exec_rise", K_EXEC, 32'd1);
    XferEnd = 1'b1; tick(); XferEnd = 1'b0;
    expect_v("ff00_exec_fall", K_EXEC, 32'd0);
    tick();
    rd_chk("ff00_cmd_after", 4'd1, 8'h10);

    // autoload, with a counter strobe on the XferEnd edge
    wr(4'd2, 8'h00); wr(4'd3, 8'hC0);
    wr(4'd7, 8'h00); wr(4'd8, 8'h01);
    wr(4'd1, 8'hB0);
    expect_v("al_exec_rise", K_EXEC, 32'd1);
    strobe(1, 0, 1);
    strobe(1, 0, 1);
    expect_v("al_ca_mid", K_CA, 32'hC002);
    rd_chk("al_len_mid", 4'd7, 8'hFE);
    IncCA = 1'b1; XferEnd = 1'b1; tick(); IncCA = 1'b0; XferEnd = 1'b0;
    expect_v("al_ca_endedge", K_CA, 32'hC003);
    expect_v("al_exec_fall", K_EXEC, 32'd0);
    tick();
    expect_v("al_ca_reload",   K_CA,   32'hC000);
    expect_v("al_reua_reload", K_REUA, 32'h00200);
    rd_chk("al_len_lo", 4'd7, 8'h00);
    rd_chk("al_len_hi", 4'd8, 8'h01);
    rd_chk("al_cmd",    4'd1, 8'h30);

    // fixed CA, REUA wrap, CA wrap, length wrap
    wr(4'd10, 8'h80);
    wr(4'd2, 8'hFF); wr(4'd3, 8'hFF);
    wr(4'd4, 8'hFF); wr(4'd5, 8'hFF); wr(4'd6, 8'h07);
    expect_v("fix_reua_load", K_REUA, 32'h7FFFF);
    strobe(1, 1, 0);
    strobe(1, 1, 0);
    expect_v("fix_ca_held", K_CA,   32'hFFFF);
    expect_v("wrap_reua",   K_REUA, 32'h00001);
    rd_chk("fix_bank", 4'd6, 8'hF8);
    rd_chk("fix_actl", 4'd10, 8'hBF);
    wr(4'd10, 8'h00);
    strobe(1, 0, 0);
    expect_v("wrap_ca", K_CA, 32'h0000);
    wr(4'd7, 8'h00); wr(4'd8, 8'h00);
    strobe(0, 0, 1);
    rd_chk("wrap_len_lo", 4'd7, 8'hFF);
    rd_chk("wrap_len_hi", 4'd8, 8'hFF);

    // status flags and interrupt
    wr(4'd9, 8'hE0);
    expect_v("irq_idle", K_NIRQ, 32'd1);
    SetVerifyErr = 1'b1; tick(); SetVerifyErr = 1'b0;
    expect_v("irq_verr_nirq", K_NIRQ, 32'd0);
    rd_chk("irq_status_b0", 4'd0, 8'hB0);
    rd_chk("irq_read_clear", 4'd0, 8'hB0, 1'b1);
    expect_v("irq_cleared_nirq", K_NIRQ, 32'd1);
    rd_chk("irq_status_10", 4'd0, 8'h10);
    RegA = 4'd0; RegRD = 1'b1; SetEndOfBlock = 1'b1;
    tick();
    RegRD = 1'b0; SetEndOfBlock = 1'b0;
    expect_v("irq_eob_nirq", K_NIRQ, 32'd0);
    rd_chk("irq_set_wins", 4'd0, 8'hD0);
    rd_chk("irq_mask_rd",  4'd9, 8'hFF);
    rd_chk("irq_clear2", 4'd0, 8'hD0, 1'b1);
    rd_chk("irq_status_10b", 4'd0, 8'h10);

    // synchronous RegReset while armed
    wr(4'd7, 8'h05); wr(4'd8, 8'h00);
    wr(4'd1, 8'h80);
    RegReset = 1'b1; tick(); RegReset = 1'b0;
    rd_chk("rr_cmd",  4'd1, 8'h10);
    rd_chk("rr_len",  4'd7, 8'hFF);
    rd_chk("rr_mask", 4'd9, 8'h1F);
    rd_chk("rr_actl", 4'd10, 8'h3F);
    FF00WR = 1'b1; tick(); FF00WR = 1'b0;
    expect_v("rr_no_launch", K_EXEC, 32'd0);
    tick();

    // asynchronous reset mid-RUN with the clock stopped
    wr(4'd7, 8'h05); wr(4'd8, 8'h00);
    wr(4'd1, 8'h90);
    expect_v("ar_exec_run", K_EXEC, 32'd1);
    tick();
    clk_en = 1'b0;
    #2;
    nRESET = 1'b0;
    #1;
    RegA = 4'd7;
    expect_v("ar_exec", K_EXEC, 32'd0);
    expect_v("ar_len",  K_DOUT, 32'hFF);
    -> chk_ev;
    #1;
    RegA = 4'd1;
    expect_v("ar_cmd", K_DOUT, 32'h10);
    -> chk_ev;
    #1;
    nRESET = 1'b1;
    #1;
    clk_en = 1'b1;
    tick();
    tick();
    expect_v("ar_stays_idle", K_EXEC, 32'd0);
    tick();
    tick();

    if (sb_q.size() != 0) begin
      $display("FAIL drain: got %0d pending expectations required 0", sb_q.size());
      n_bad += sb_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reu_exec_ctrl.md
# reu_exec_ctrl

REU register file and transfer scheduler. It holds the CPU-visible REU registers ($DF00–$DF0A), arms and launches transfers (immediately or on the $FF00 write trigger), and owns the C64 address, REU address and length counters that the DMA sequencer steps. It also applies autoload at end of transfer and generates the status flags and interrupt. It sits between the C64 bus decode and the DMA sequencer, and drives that sequencer's Execute, XferType and Length1 inputs.

## Interface
- REUA_BITS, 19: REU address width, 17..24; bank register holds bits [REUA_BITS-1:16].
- PHI2  in  1  C64 clock; all state updates on falling edge.
- nRESET  in  1  asynchronous active-low reset.
- RegReset  in  1  synchronous clear from DMA sequencer; same effect as reset, sampled on negedge.
- RegWR / RegRD  in  1 / 1  CPU write / read of REU window this cycle.
- RegA  in  4  register offset 0..15.
- Din  in  8  CPU write data.
- Dout  out  8  read data, combinational from RegA.
- FF00WR  in  1  CPU write to $FF00 this cycle.
- IncCA, DecLen, IncREUA, XferEnd, SetEndOfBlock, SetVerifyErr  in  1 each  from DMA sequencer.
- Execute  out  1  registered; starts and holds transfer.
- XferType  out  2  command bits [1:0].
- Length1  out  1  length == 1.
- CA  out  16  C64 address.
- REUA  out  REUA_BITS  REU address.
- nIRQ  out  1  active-low interrupt.

## Operation
- Registers:
  - 0 status: b7 IRQ pending, b6 end-of-block, b5 fault, b4 = (REUA_BITS≥19), b3:0 = 0.
  - 1 command: b7 execute, b5 autoload, b4 FF00-disable, b1:0 type.
  - 2/3 CA lo/hi. 4/5 REUA lo/hi. 6 bank. 7/8 length lo/hi.
  - 9 IRQ mask: b7 enable, b6 EOB, b5 verify.
  - 10 address control: b7 fix CA, b6 fix REUA.
- Unused register bits read 1; offsets 11–15 read $FF; writes to them are ignored.
- Reset / RegReset values: status flags 0, command $10, CA 0, REUA 0, length $FFFF, mask $1F, addr ctrl $3F, Execute 0, state IDLE.
- CA/REUA/length writes load both the live counter and its autoload shadow byte.
- Status read (RegRD, RegA=0) clears b7:5 at that negedge. A simultaneous set event wins over the clear.
- Flag set rules:
  - SetEndOfBlock sets b6.
  - SetVerifyErr sets b5.
  - b7 = mask.b7 && ((b6 && mask.b6) || (b5 && mask.b5)).
  - nIRQ = !b7.
- State machine:
  - IDLE: command write with b7=1, b4=1 → RUN. With b7=1, b4=0 → ARMED. With b7=0 → stay (fields update).
  - ARMED: FF00WR → RUN. Command write with b7=0 → IDLE. FF00WR in IDLE is ignored.
  - RUN: Execute=1. XferEnd sampled 1 → DONE, and Execute clears at that same negedge.
  - DONE (one cycle): clear command b7, set command b4. If autoload, reload CA/REUA/length from shadows; else counters keep final values. → IDLE.
- Counter rules:
  - IncCA increments CA unless fix-CA; wraps $FFFF→$0000.
  - IncREUA increments REUA unless fix-REUA; wraps modulo 2^REUA_BITS.
  - DecLen decrements length; length $0000 means 65536 and decrements to $FFFF.
- Register writes while in RUN or DONE are ignored, since the CPU is halted by DMA.

## Timing
- Execute rises at the first negedge after the launching write: the command write with b4=1, or FF00WR.
- Counter updates land at the same negedge the sequencer strobe is sampled.
- Length1 and Dout are combinational from current register state; zero-cycle.
- XferEnd plus a counter strobe on the same edge: both take effect, then autoload in DONE overrides the counter values.
- nRESET low mid-transfer clears everything asynchronously. RegReset arriving after DMA abort clears synchronously.
- nIRQ follows status one cycle after the set event.

## Test plan
- Immediate launch: CA=$1000, REUA=$00200, len=3, cmd=$90 → Execute high next negedge. 3 IncCA/IncREUA/DecLen strobes give CA=$1003, REUA=$00203; Length1 is high after the second DecLen. XferEnd → Execute low at that edge; cmd reads $10.
- FF00 trigger: cmd=$80 → Execute stays 0 for 10 cycles. FF00WR → Execute=1 next negedge.
- Autoload: cmd=$B0, CA=$C000, len=$0100; run to XferEnd → CA=$C000, len=$0100 after DONE.
- Fix addresses and wrap: addr ctrl=$80, CA=$FFFF, REUA=$7FFFF, 2 strobes → CA=$FFFF, REUA=$00001.
- IRQ: mask=$E0, SetVerifyErr pulse → status reads $B0, nIRQ=0. Status read → status $10, nIRQ=1 next cycle. A read coincident with SetEndOfBlock leaves b6 set.
- Reset mid-RUN: nRESET low → Execute=0, length=$FFFF, cmd=$10 immediately, with no PHI2 edge needed.
